ascon_perm_engine: RTL and testbench
====================================

Name: ascon_perm_engine

Overview:
- Multi-round Ascon permutation engine: runs p12, p8 or p6 on a 320-bit state from a single start request and signals completion.
- UNROLL rounds are evaluated per clock, with cycle-level sequencing handled internally.
- Sits between the Ascon-128 mode controller (init / associated data / plaintext / finalisation) and the state register file.
- Replaces the externally sequenced single-round step, whose caller drove the round index and input mux every cycle.

Parameters:
- UNROLL, 1: rounds evaluated per clock; legal 1..4. Elaboration error otherwise.
- RESET_STATE_ZERO, 1: 1 = state_o clears to zero on reset; 0 = state register is not reset (area option).

Ports:
- clock_i  in  1  clock, rising edge.
- reset_i  in  1  synchronous active-high reset.
- start_i  in  1  request; accepted only when ready_o=1.
- mode_i  in  2  00=p12, 01=p8, 10=p6, 11=reserved; sampled with start.
- state_i  in  type_state (5x64)  input state; sampled with start.
- ready_o  out  1  engine idle, start accepted.
- busy_o  out  1  permutation in progress.
- done_o  out  1  one-cycle pulse; state_o holds the final result.
- err_o  out  1  one-cycle pulse; start with mode 11 was rejected.
- state_o  out  type_state  working/result state; holds after done until the next accepted start.

Behaviour:
- Reset (sync, reset_i=1 at edge):
  - FSM goes to IDLE; rnd_cnt=0.
  - done_o=0, err_o=0, busy_o=0, ready_o=1.
  - state_o=0 if RESET_STATE_ZERO=1.
  - Reset overrides start_i in the same cycle.
  - Reset mid-RUN abandons the operation; no done_o.
- Round count N: 12, 8 or 6 from mode_i. The first round index is r0=12-N. Rounds use indices r0..11.
- Round constant for index r: c = ((15-r)<<4) | r, added to x2 (0xf0 for r=0 … 0x4b for r=11).
- Datapath:
  - UNROLL chained round units.
  - Unit k uses index rnd_cnt+k. It is bypassed (passes input through) when rnd_cnt+k > 11.
  - Chain input is state_i on the start cycle, else the state register.
  - Chain output is registered into state_o.
- FSM IDLE:
  - ready_o=1.
  - start_i=1 with mode≠11:
    - loads chain(state_i) into state_o; rnd_cnt=r0+UNROLL.
    - If rnd_cnt ≥ 12 after the load: done_o=1 next cycle and stay IDLE; else go to RUN.
  - start_i=1 with mode=11: err_o=1 next cycle; state_o unchanged; stay IDLE.
- FSM RUN:
  - ready_o=0, busy_o=1. start_i is ignored (no err_o).
  - Each edge: state_o ← chain(state_o); rnd_cnt += UNROLL.
  - When the new rnd_cnt ≥ 12: done_o=1 in the following cycle; go to IDLE.
- Latency: ceil(N/UNROLL) clock edges from the accepting edge to the edge after which done_o=1.
  - UNROLL=1: p12 12 cycles, p8 8, p6 6.
  - UNROLL=4: p12 3, p8 2, p6 2 (second cycle uses 2 units, 2 bypassed).
- Back-to-back: a start in the same cycle done_o=1 is accepted (ready_o=1 in that cycle). No bubble.
- done_o and err_o are registered, never asserted together, and never asserted for more than one cycle.
- rnd_cnt is 4 bits plus a carry. The bypass comparison uses the 5-bit sum, so there is no wrap at 15.

Decomposition:
- ascon_pack holds:
  - type_state (array 0..4 of 64-bit);
  - mode encodings (MODE_P12/P8/P6/RSV);
  - function round_const(r) returning 8 bits;
  - function n_rounds(mode).
- Sub-module ascon_round_unit: one combinational round with ports state in, 4-bit round index in, bypass in, state out.
  - Round order: constant addition, 5-bit S-box substitution layer, linear diffusion.
  - Rotations per word: x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41).
- The engine instantiates the units with a generate loop over UNROLL.

Test Plan:
- UNROLL=1, p12, state_i = Ascon-128 init:
  - x0=0x80400c0600000000, x1..x2 = key 0x000102030405060708090a0b0c0d0e0f, x3..x4 = nonce same pattern.
  - Required: done_o exactly 12 cycles after start; state_o equals golden C model; ready_o low for 11 cycles.
- UNROLL=1, p6 then p8 back-to-back on the same state:
  - Second start is asserted in the done_o cycle.
  - Required: done after 6 then 8 more cycles; both results equal the model; no idle cycle between them.
- Sweep UNROLL=2,3,4 × all modes with random states:
  - Required: results bit-identical to UNROLL=1.
  - Cycle counts are 6/4/3 (U=2), 4/3/2 (U=3), 3/2/2 (U=4).
- Illegal mode and ignored start:
  - start with mode_i=11 → err_o pulse 1 cycle later; state_o unchanged; ready_o stays 1.
  - start pulsed during RUN → no effect on result or timing.
- Reset mid-operation:
  - Assert reset_i on cycle 5 of a p12 run → state_o=0, ready_o=1, no done_o.
  - A new p12 start 2 cycles later completes normally in 12 cycles.
- Hold behaviour:
  - After done_o, with start_i=0 for 20 cycles → state_o stable; done_o stays low after the pulse.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared types, mode encodings and helpers for the Ascon permutation engine.
package ascon_pack;

  // Word x0 is element 0.
  typedef logic [0:4][63:0] type_state;

  localparam logic [1:0] MODE_P12 = 2'b00;
  localparam logic [1:0] MODE_P8  = 2'b01;
  localparam logic [1:0] MODE_P6  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'd15 - r, r};
  endfunction

  function automatic logic [3:0] n_rounds(input logic [1:0] mode);
    case (mode)
      MODE_P12: return 4'd12;
      MODE_P8:  return 4'd8;
      MODE_P6:  return 4'd6;
      default:  return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ascon_round_unit.sv
// One combinational Ascon round: constant addition, bitsliced S-box, linear diffusion.
module ascon_round_unit
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] rnd_i,
  input  logic       bypass_i,
  output type_state  state_o
);

  function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  logic [63:0] c2;
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] s0, s1, s2, s3, s4;
  type_state   rnd_out;

  assign c2 = state_i[2] ^ {56'd0, round_const(rnd_i)};

  assign a0 = state_i[0] ^ state_i[4];
  assign a1 = state_i[1];
  assign a2 = c2 ^ state_i[1];
  assign a3 = state_i[3];
  assign a4 = state_i[4] ^ state_i[3];

  // chi-like core of the S-box
  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  assign s0 = b0 ^ b4;
  assign s1 = b1 ^ b0;
  assign s2 = ~b2;
  assign s3 = b3 ^ b2;
  assign s4 = b4;

  assign rnd_out[0] = s0 ^ ror(s0, 19) ^ ror(s0, 28);
  assign rnd_out[1] = s1 ^ ror(s1, 61) ^ ror(s1, 39);
  assign rnd_out[2] = s2 ^ ror(s2, 1)  ^ ror(s2, 6);
  assign rnd_out[3] = s3 ^ ror(s3, 10) ^ ror(s3, 17);
  assign rnd_out[4] = s4 ^ ror(s4, 7)  ^ ror(s4, 41);

  assign state_o = bypass_i ? state_i : rnd_out;

endmodule

// File: rtl/ascon_perm_engine.sv
// Self-sequenced Ascon p12/p8/p6 permutation, UNROLL rounds per clock.
module ascon_perm_engine
  import ascon_pack::*;
#(
  parameter int unsigned UNROLL           = 1,
  parameter bit          RESET_STATE_ZERO = 1'b1
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  type_state  state_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output type_state  state_o
);

  if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be in 1..4");
  end

  typedef enum logic [0:0] {StIdle, StRun} fsm_e;

  fsm_e       fsm_q, fsm_d;
  logic [4:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  type_state  state_q, state_d;

  logic       accept;
  logic [4:0] r0, base, cnt_sum;
  type_state  chain [UNROLL+1];

  assign accept  = (fsm_q == StIdle) && start_i && (mode_i != MODE_RSV);
  assign r0      = 5'd12 - {1'b0, n_rounds(mode_i)};
  assign base    = accept ? r0 : cnt_q;
  assign cnt_sum = base + 5'(UNROLL);
  assign chain[0] = accept ? state_i : state_q;

  // 5-bit index so units beyond round 11 bypass instead of wrapping
  for (genvar k = 0; k < UNROLL; k++) begin : g_unit
    logic [4:0] idx;
    assign idx = base + 5'(k);
    ascon_round_unit u_round (
      .state_i (chain[k]),
      .rnd_i   (idx[3:0]),
      .bypass_i(idx > 5'd11),
      .state_o (chain[k+1])
    );
  end

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        if (start_i) begin
          if (mode_i == MODE_RSV) begin
            err_d = 1'b1;
          end else begin
            state_d = chain[UNROLL];
            cnt_d   = cnt_sum;
            if (cnt_sum >= 5'd12) done_d = 1'b1;
            else                  fsm_d  = StRun;
          end
        end
      end
      StRun: begin
        state_d = chain[UNROLL];
        cnt_d   = cnt_sum;
        if (cnt_sum >= 5'd12) begin
          done_d = 1'b1;
          fsm_d  = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q  <= StIdle;
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  if (RESET_STATE_ZERO) begin : g_state_rst
    always_ff @(posedge clock_i) begin
      if (reset_i) state_q <= '0;
      else         state_q <= state_d;
    end
  end else begin : g_state_norst
    always_ff @(posedge clock_i) begin
      state_q <= state_d;
    end
  end

  assign ready_o = (fsm_q == StIdle);
  assign busy_o  = (fsm_q == StRun);
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Bench: UNROLL=1..4 engines on shared inputs, checked against a table-lookup Ascon model.
module tb_ascon_perm_engine;
  import ascon_pack::*;

  localparam int NU = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  type_state  st_in = '0;

  logic      rdy [NU];
  logic      bsy [NU];
  logic      dn  [NU];
  logic      er  [NU];
  type_state so  [NU];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    ascon_perm_engine #(
      .UNROLL          (g + 1),
      .RESET_STATE_ZERO(1'b1)
    ) u_dut (
      .clock_i(clk),
      .reset_i(rst),
      .start_i(start),
      .mode_i (mode),
      .state_i(st_in),
      .ready_o(rdy[g]),
      .busy_o (bsy[g]),
      .done_o (dn[g]),
      .err_o  (er[g]),
      .state_o(so[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  // Reference model: 5-bit S-box lookup per bit column, rounds 12-n..11.
  logic [4:0] sbox_tab [32];

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic type_state model_perm(input type_state s, input int n);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col, o;
    int rot_a [5] = '{19, 61, 1, 10, 7};
    int rot_b [5] = '{28, 39, 6, 17, 41};
    type_state res;
    for (int i = 0; i < 5; i++) x[i] = s[i];
    for (int r = 12 - n; r < 12; r++) begin
      x[2] = x[2] ^ 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o   = sbox_tab[col];
        for (int i = 0; i < 5; i++) y[i][b] = o[4-i];
      end
      for (int i = 0; i < 5; i++) x[i] = y[i] ^ rotr(y[i], rot_a[i]) ^ rotr(y[i], rot_b[i]);
    end
    for (int i = 0; i < 5; i++) res[i] = x[i];
    return res;
  endfunction

  function automatic type_state rand_st();
    type_state r;
    for (int i = 0; i < 5; i++) r[i] = {$urandom, $urandom};
    return r;
  endfunction

  function automatic int mode_n(input logic [1:0] m);
    return (m == MODE_P12) ? 12 : (m == MODE_P8) ? 8 : 6;
  endfunction

  typedef struct {
    logic [1:0] mode;
    type_state  st;
    type_state  exp;
    int         n;
  } vec_t;

  vec_t vecs [9];

  // One start; checks latency, single done pulse, ready-low time and result on every instance.
  task automatic do_op(input logic [1:0] m, input type_state s, input type_state exp,
                       input int n, input bit poke, input string tag);
    int        lat    [NU];
    int        pulses [NU];
    int        rlow   [NU];
    type_state got    [NU];
    int        errs;
    int        want;
    errs = 0;
    for (int u = 0; u < NU; u++) begin
      lat[u] = -1; pulses[u] = 0; rlow[u] = 0; got[u] = '0;
    end
    @(negedge clk);
    start = 1'b1; mode = m; st_in = s;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (poke && j == 1) begin
        start = 1'b1; mode = MODE_P8; st_in = rand_st();
      end else begin
        start = 1'b0;
      end
      for (int u = 0; u < NU; u++) begin
        if (er[u]) errs++;
        if (!rdy[u] && lat[u] < 0) rlow[u]++;
        if (dn[u]) begin
          pulses[u]++;
          if (lat[u] < 0) begin
            lat[u] = j;
            got[u] = so[u];
          end
        end
      end
    end
    for (int u = 0; u < NU; u++) begin
      want = (n + u) / (u + 1);
      chk($sformatf("%s_lat_u%0d", tag, u + 1), 320'(lat[u]), 320'(want));
      chk($sformatf("%s_pulses_u%0d", tag, u + 1), 320'(pulses[u]), 320'd1);
      chk($sformatf("%s_ready_low_u%0d", tag, u + 1), 320'(rlow[u]), 320'(want - 1));
      chk($sformatf("%s_result_u%0d", tag, u + 1), got[u], exp);
      chk($sformatf("%s_held_u%0d", tag, u + 1), so[u], exp);
    end
    chk({tag, "_no_err"}, 320'(errs), 320'd0);
  endtask

  initial begin
    type_state init_st, s, prev [NU], e;
    int lat1, lat2, viol;

    sbox_tab = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                 5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    init_st[0] = 64'h80400c0600000000;
    init_st[1] = 64'h0001020304050607;
    init_st[2] = 64'h08090a0b0c0d0e0f;
    init_st[3] = 64'h0001020304050607;
    init_st[4] = 64'h08090a0b0c0d0e0f;

    for (int i = 0; i < 9; i++) begin
      vecs[i].mode = (i % 3 == 0) ? MODE_P12 : (i % 3 == 1) ? MODE_P8 : MODE_P6;
      vecs[i].st   = (i < 3) ? init_st : rand_st();
      vecs[i].n    = mode_n(vecs[i].mode);
      vecs[i].exp  = model_perm(vecs[i].st, vecs[i].n);
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < NU; u++) begin
      chk($sformatf("rst_state_u%0d", u + 1), so[u], '0);
      chk($sformatf("rst_ready_u%0d", u + 1), 320'(rdy[u]), 320'd1);
      chk($sformatf("rst_busy_u%0d", u + 1), 320'(bsy[u]), 320'd0);
      chk($sformatf("rst_done_u%0d", u + 1), 320'(dn[u] | er[u]), 320'd0);
    end

    // Table sweep over modes, init vector and random states
    for (int i = 0; i < 9; i++)
      do_op(vecs[i].mode, vecs[i].st, vecs[i].exp, vecs[i].n, 1'b0, $sformatf("vec%0d", i));

    // Hold after done
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int u = 0; u < NU; u++)
        if (so[u] !== vecs[8].exp || dn[u]) viol++;
    end
    chk("hold_stable", 320'(viol), 320'd0);

    // Illegal mode
    for (int u = 0; u < NU; u++) prev[u] = so[u];
    @(negedge clk);
    start = 1'b1; mode = MODE_RSV; st_in = rand_st();
    @(negedge clk);
    start = 1'b0; mode = MODE_P12;
    for (int u = 0; u < NU; u++) begin
      chk($sformatf("illegal_err_u%0d", u + 1), 320'(er[u]), 320'd1);
      chk($sformatf("illegal_nodone_u%0d", u + 1), 320'(dn[u]), 320'd0);
      chk($sformatf("illegal_ready_u%0d", u + 1), 320'(rdy[u]), 320'd1);
      chk($sformatf("illegal_state_u%0d", u + 1), so[u], prev[u]);
    end
    @(negedge clk);
    for (int u = 0; u < NU; u++)
      chk($sformatf("illegal_err_pulse_u%0d", u + 1), 320'(er[u]), 320'd0);

    // Start pulsed while running is ignored
    s = rand_st();
    do_op(MODE_P12, s, model_perm(s, 12), 12, 1'b1, "poke");

    // Back-to-back p6 then p8 on U=1, second start in the done cycle
    s = rand_st();
    lat1 = -1; lat2 = -1;
    @(negedge clk);
    start = 1'b1; mode = MODE_P6; st_in = s;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (dn[0]) begin
        lat1 = j;
        chk("b2b_p6_result", so[0], model_perm(s, 6));
        chk("b2b_ready_in_done", 320'(rdy[0]), 320'd1);
        start = 1'b1; mode = MODE_P8;
        break;
      end
    end
    for (int j = 1; j <= 16 && lat1 > 0; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j == 1) chk("b2b_no_bubble", 320'(bsy[0]), 320'd1);
      if (dn[0]) begin
        lat2 = j;
        chk("b2b_p8_result", so[0], model_perm(s, 8));
        break;
      end
    end
    chk("b2b_lat_p6", 320'(lat1), 320'd6);
    chk("b2b_lat_p8", 320'(lat2), 320'd8);
    start = 1'b0;
    repeat (16) @(negedge clk);

    // Reset on cycle 5 of a p12 run
    @(negedge clk);
    start = 1'b1; mode = MODE_P12; st_in = rand_st();
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < NU; u++) begin
      chk($sformatf("midrst_state_u%0d", u + 1), so[u], '0);
      chk($sformatf("midrst_ready_u%0d", u + 1), 320'(rdy[u]), 320'd1);
      chk($sformatf("midrst_busy_u%0d", u + 1), 320'(bsy[u]), 320'd0);
      chk($sformatf("midrst_nodone_u%0d", u + 1), 320'(dn[u]), 320'd0);
    end
    @(negedge clk);
    chk("midrst_nodone_later", 320'(dn[0]), 320'd0);
    s = rand_st();
    e = model_perm(s, 12);
    do_op(MODE_P12, s, e, 12, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
